// File: rtl/core_mem_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : core_mem_bridge_if
// Brief    : Arbiter request/response and Avalon-MM master signals of the
//            core memory bridge. 'master' is the bridge view, 'slave' the
//            arbiter-plus-memory view.
// Revision : 1.0 - initial release
//==============================================================================
interface core_mem_bridge_if;
    logic        texture_req_in;
    logic [23:0] texture_addr_in;
    logic [6:0]  texture_core_id_in;
    logic        texture_valid_out;
    logic [31:0] texture_data_out;
    logic        texture_read_done_in;
    logic        write_req_in;
    logic [31:0] write_addr_in;
    logic [31:0] write_data_in;
    logic [6:0]  write_core_id_in;
    logic        write_valid_out;
    logic        write_done_out;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        input  texture_req_in, texture_addr_in, texture_core_id_in, texture_read_done_in,
        input  write_req_in, write_addr_in, write_data_in, write_core_id_in,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output texture_valid_out, texture_data_out, write_valid_out, write_done_out,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output texture_req_in, texture_addr_in, texture_core_id_in, texture_read_done_in,
        output write_req_in, write_addr_in, write_data_in, write_core_id_in,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  texture_valid_out, texture_data_out, write_valid_out, write_done_out,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );
endinterface
`default_nettype wire

// File: rtl/core_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : core_mem_bridge
// Brief    : Converts arbitrated texture-read / pixel-write requests into
//            single-word Avalon-MM accesses, one transaction at a time.
//            Optional single-entry read cache: CORE_MEM_BRIDGE_TEX_CACHE_EN.
// Revision : 1.0 - initial release
//==============================================================================
module core_mem_bridge #(
    parameter logic [31:0] TEX_BASE_ADDR = 32'h0000_0000,
    parameter int          RD_TIMEOUT    = 1023,
    parameter logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    core_mem_bridge_if.master bus,
    output logic              busy,
    output logic              err_timeout
);
    localparam int                 c_CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_CMD  = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wr_data;
    logic [31:0]        r_rd_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic [6:0]         r_dbg_core_id;
    logic               r_err_timeout;
    logic [31:0]        w_tex_addr;
    logic               w_cnt_done;
    logic               w_cache_hit;
    logic [31:0]        w_cache_data;
    logic               w_rd_cmd;
    logic               w_wr_cmd;
    logic               w_unused;

    assign w_tex_addr = TEX_BASE_ADDR + {6'd0, bus.texture_addr_in, 2'b00};
    assign w_cnt_done = (r_cnt == c_CNT_LAST);
    assign w_unused   = ^{r_dbg_core_id, bus.write_addr_in[1:0]};

`ifdef CORE_MEM_BRIDGE_TEX_CACHE_EN
    logic        r_cache_valid;
    logic [31:0] r_cache_tag;
    logic [31:0] r_cache_data;

    // Timed-out reads never fill; any write to the cached word kills the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
            r_cache_data  <= '0;
        end else if (r_state == RD_WAIT && bus.avm_readdatavalid) begin
            r_cache_valid <= 1'b1;
            r_cache_tag   <= r_addr;
            r_cache_data  <= bus.avm_readdata;
        end else if (r_state == WR_CMD && r_addr == r_cache_tag) begin
            r_cache_valid <= 1'b0;
        end
    end

    assign w_cache_hit  = r_cache_valid && (r_cache_tag == w_tex_addr);
    assign w_cache_data = r_cache_data;
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_data = 32'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.texture_req_in)    w_state_nxt = w_cache_hit ? RD_RESP : RD_CMD;
                else if (bus.write_req_in) w_state_nxt = WR_CMD;
            end
            RD_CMD:  if (!bus.avm_waitrequest) w_state_nxt = RD_WAIT;
            RD_WAIT: if (bus.avm_readdatavalid || w_cnt_done) w_state_nxt = RD_RESP;
            RD_RESP: if (bus.texture_read_done_in || !bus.texture_req_in) w_state_nxt = IDLE;
            WR_CMD:  if (!bus.avm_waitrequest) w_state_nxt = WR_RESP;
            WR_RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_rd_data     <= '0;
            r_cnt         <= '0;
            r_dbg_core_id <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.texture_req_in) begin
                        r_addr        <= w_tex_addr;
                        r_dbg_core_id <= bus.texture_core_id_in;
                        if (w_cache_hit) r_rd_data <= w_cache_data;
                    end else if (bus.write_req_in) begin
                        r_addr        <= {bus.write_addr_in[31:2], 2'b00};
                        r_wr_data     <= bus.write_data_in;
                        r_dbg_core_id <= bus.write_core_id_in;
                    end
                end
                RD_WAIT: begin
                    if (bus.avm_readdatavalid) begin
                        r_rd_data <= bus.avm_readdata;
                    end else if (w_cnt_done) begin
                        r_rd_data     <= TIMEOUT_DATA;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Command outputs decode from state so reset removes them asynchronously.
    assign w_rd_cmd               = (r_state == RD_CMD);
    assign w_wr_cmd               = (r_state == WR_CMD);
    assign bus.avm_read           = w_rd_cmd;
    assign bus.avm_write          = w_wr_cmd;
    assign bus.avm_address        = (w_rd_cmd || w_wr_cmd) ? r_addr : 32'd0;
    assign bus.avm_writedata      = w_wr_cmd ? r_wr_data : 32'd0;
    assign bus.avm_byteenable     = (w_rd_cmd || w_wr_cmd) ? 4'hF : 4'h0;
    assign bus.texture_valid_out  = (r_state == RD_RESP);
    assign bus.texture_data_out   = r_rd_data;
    assign bus.write_valid_out    = (r_state == WR_RESP);
    assign bus.write_done_out     = (r_state == WR_RESP);
    assign busy                   = (r_state != IDLE);
    assign err_timeout            = r_err_timeout;
endmodule
`default_nettype wire

// File: tb/tb_core_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_core_mem_bridge
// Brief    : Directed plus randomized bench for core_mem_bridge, acting as
//            arbiter and Avalon slave against a word-memory/cache model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_core_mem_bridge;
    localparam logic [31:0] TEX_BASE = 32'h1000_0000;
    localparam int          RD_TO    = 8;
    localparam logic [31:0] TO_DATA  = 32'hDEAD_BEEF;
`ifdef CORE_MEM_BRIDGE_TEX_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_timeout;

    core_mem_bridge_if bus ();

    core_mem_bridge #(
        .TEX_BASE_ADDR (TEX_BASE),
        .RD_TIMEOUT    (RD_TO),
        .TIMEOUT_DATA  (TO_DATA)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: external memory by word address, sticky error, cache entry.
    logic [31:0] mem [logic [31:0]];
    logic        m_err    = 1'b0;
    logic        mc_valid = 1'b0;
    logic [31:0] mc_tag   = '0;
    logic [31:0] mc_data  = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [23:0] a, input int ws, input int lat,
                           input int hold, input bit abandon, input bit timeout);
        logic [31:0] ba;
        logic [31:0] exp_d;
        bit          hit;
        ba  = TEX_BASE + 32'(a) * 32'd4;
        hit = CACHE_EN && mc_valid && (mc_tag == ba);
        bus.texture_req_in     = 1'b1;
        bus.texture_addr_in    = a;
        bus.texture_core_id_in = 7'($urandom);
        step;
        if (hit) begin
            exp_d = mc_data;
            chk1("hit_no_avm_read", bus.avm_read, 1'b0);
        end else begin
            for (int k = 0; k <= ws; k++) begin
                chk1 ("rd_cmd_read", bus.avm_read, 1'b1);
                chk32("rd_cmd_addr", bus.avm_address, ba);
                chk32("rd_cmd_be", 32'(bus.avm_byteenable), 32'hF);
                chk1 ("rd_cmd_nowrite", bus.avm_write, 1'b0);
                chk1 ("rd_cmd_valid", bus.texture_valid_out, 1'b0);
                bus.avm_waitrequest   = (k < ws);
                bus.avm_readdatavalid = 1'($urandom_range(0, 1));
                bus.avm_readdata      = $urandom;
                step;
            end
            bus.avm_waitrequest = 1'b0;
            if (timeout) begin
                bus.avm_readdatavalid = 1'b0;
                for (int k = 0; k < RD_TO; k++) begin
                    chk1("to_wait_valid", bus.texture_valid_out, 1'b0);
                    chk1("to_wait_read", bus.avm_read, 1'b0);
                    step;
                end
                exp_d = TO_DATA;
                m_err = 1'b1;
            end else begin
                exp_d = mem_rd(ba);
                for (int k = 1; k <= lat; k++) begin
                    chk1("rd_wait_valid", bus.texture_valid_out, 1'b0);
                    chk1("rd_wait_read", bus.avm_read, 1'b0);
                    bus.avm_readdatavalid = (k == lat);
                    bus.avm_readdata      = (k == lat) ? exp_d : $urandom;
                    step;
                end
                bus.avm_readdatavalid = 1'b0;
                mc_valid = 1'b1;
                mc_tag   = ba;
                mc_data  = exp_d;
            end
        end
        chk1 ("rd_valid", bus.texture_valid_out, 1'b1);
        chk32("rd_data", bus.texture_data_out, exp_d);
        chk1 ("rd_err", err_timeout, m_err);
        chk1 ("rd_busy", busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            step;
            chk1 ("rd_hold_valid", bus.texture_valid_out, 1'b1);
            chk32("rd_hold_data", bus.texture_data_out, exp_d);
        end
        if (abandon) bus.texture_req_in = 1'b0;
        else         bus.texture_read_done_in = 1'b1;
        step;
        bus.texture_read_done_in = 1'b0;
        bus.texture_req_in       = 1'b0;
        chk1 ("rd_end_valid", bus.texture_valid_out, 1'b0);
        chk1 ("rd_end_busy", busy, 1'b0);
        chk32("rd_end_data_held", bus.texture_data_out, exp_d);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int ws);
        logic [31:0] wa;
        wa = a & ~32'h3;
        bus.write_req_in     = 1'b1;
        bus.write_addr_in    = a;
        bus.write_data_in    = d;
        bus.write_core_id_in = 7'($urandom);
        step;
        for (int k = 0; k <= ws; k++) begin
            chk1 ("wr_cmd_write", bus.avm_write, 1'b1);
            chk32("wr_cmd_addr", bus.avm_address, wa);
            chk32("wr_cmd_data", bus.avm_writedata, d);
            chk32("wr_cmd_be", 32'(bus.avm_byteenable), 32'hF);
            chk1 ("wr_cmd_noread", bus.avm_read, 1'b0);
            chk1 ("wr_cmd_done", bus.write_done_out, 1'b0);
            bus.avm_waitrequest = (k < ws);
            step;
        end
        bus.avm_waitrequest = 1'b0;
        chk1("wr_resp_valid", bus.write_valid_out, 1'b1);
        chk1("wr_resp_done", bus.write_done_out, 1'b1);
        chk1("wr_resp_nowrite", bus.avm_write, 1'b0);
        bus.write_req_in = 1'b0;
        step;
        chk1("wr_end_done", bus.write_done_out, 1'b0);
        chk1("wr_end_valid", bus.write_valid_out, 1'b0);
        chk1("wr_end_busy", busy, 1'b0);
        mem[wa] = d;
        if (mc_valid && mc_tag == wa) mc_valid = 1'b0;
    endtask

    task automatic apply_reset;
        bus.texture_req_in       = 1'b0;
        bus.texture_read_done_in = 1'b0;
        bus.write_req_in         = 1'b0;
        bus.avm_waitrequest      = 1'b0;
        rst_n                    = 1'b0;
        m_err                    = 1'b0;
        mc_valid                 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ta;
        logic [31:0] wa;
        bus.texture_req_in       = 1'b0;
        bus.texture_addr_in      = '0;
        bus.texture_core_id_in   = '0;
        bus.texture_read_done_in = 1'b0;
        bus.write_req_in         = 1'b0;
        bus.write_addr_in        = '0;
        bus.write_data_in        = '0;
        bus.write_core_id_in     = '0;
        bus.avm_waitrequest      = 1'b0;
        bus.avm_readdata         = '0;
        bus.avm_readdatavalid    = 1'b0;

        step;
        step;
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_read", bus.avm_read, 1'b0);
        chk1 ("rst_write", bus.avm_write, 1'b0);
        chk32("rst_addr", bus.avm_address, 32'h0);
        chk32("rst_be", 32'(bus.avm_byteenable), 32'h0);
        chk1 ("rst_tvalid", bus.texture_valid_out, 1'b0);
        chk32("rst_tdata", bus.texture_data_out, 32'h0);
        chk1 ("rst_wdone", bus.write_done_out, 1'b0);
        chk1 ("rst_err", err_timeout, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step;

        // Zero-wait read, then stalled write.
        mem[32'h1000_0040] = 32'hCAFE_F00D;
        do_read(24'h000010, 0, 1, 2, 1'b0, 1'b0);
        do_write(32'h2000_0007, 32'h1234_5678, 3);

        // Timeout, then good reads keep the sticky error.
        do_read(24'h000033, 0, 0, 1, 1'b0, 1'b1);
        do_read(24'h000011, 1, 2, 0, 1'b0, 1'b0);
        do_read(24'h000010, 0, 1, 0, 1'b0, 1'b0);

        // Simultaneous requests: read first, write after one idle cycle.
        bus.write_req_in     = 1'b1;
        bus.write_addr_in    = 32'h3000_0100;
        bus.write_data_in    = 32'h0BAD_F00D;
        bus.write_core_id_in = 7'd5;
        do_read(24'h000040, 0, 1, 1, 1'b0, 1'b0);
        chk1("simul_idle_nowrite", bus.avm_write, 1'b0);
        do_write(32'h3000_0100, 32'h0BAD_F00D, 0);

        // Repeated read, matching write, third read.
        do_read(24'h000020, 0, 1, 0, 1'b0, 1'b0);
        do_read(24'h000020, 0, 1, 0, 1'b0, 1'b0);
        do_write(32'h1000_0082, 32'h5555_AAAA, 1);
        do_read(24'h000020, 0, 1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ta = 24'($urandom_range(0, 7)) + 24'h000100;
            if ($urandom_range(0, 2) != 0) begin
                do_read(ta, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3),
                        ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
            end else begin
                if ($urandom_range(0, 1) != 0) wa = TEX_BASE + 32'(ta) * 32'd4 + 32'($urandom_range(0, 3));
                else                           wa = $urandom;
                do_write(wa, $urandom, $urandom_range(0, 3));
            end
        end

        // Reset while waiting for read data; stale readdatavalid afterwards.
        bus.texture_req_in  = 1'b1;
        bus.texture_addr_in = 24'h000077;
        step;
        step;
        chk1("pre_rst_busy", busy, 1'b1);
        #2;
        apply_reset;
        #1;
        chk1 ("rstw_busy", busy, 1'b0);
        chk1 ("rstw_read", bus.avm_read, 1'b0);
        chk1 ("rstw_tvalid", bus.texture_valid_out, 1'b0);
        chk1 ("rstw_err", err_timeout, 1'b0);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h7777_7777;
        @(negedge clk) rst_n = 1'b1;
        step;
        bus.avm_readdatavalid = 1'b0;
        step;
        chk1 ("stale_tvalid", bus.texture_valid_out, 1'b0);
        chk1 ("stale_busy", busy, 1'b0);
        chk32("stale_tdata", bus.texture_data_out, 32'h0);

        // Reset while the read command is stalled drops avm_read at once.
        bus.texture_req_in  = 1'b1;
        bus.texture_addr_in = 24'h000078;
        bus.avm_waitrequest = 1'b1;
        step;
        chk1("pre_rst_read", bus.avm_read, 1'b1);
        #2;
        apply_reset;
        #1;
        chk1 ("rstc_read", bus.avm_read, 1'b0);
        chk32("rstc_addr", bus.avm_address, 32'h0);
        chk32("rstc_be", 32'(bus.avm_byteenable), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step;

        do_read(24'h000010, 0, 1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
- Sits directly downstream of the 2-to-1 core arbiter.
- Consumes its unified texture-read and pixel-write request interfaces and converts each transaction into a single-word Avalon-MM master access to external memory.
- Returns the response using the arbiter's valid/done handshake.
- Handles one transaction at a time; no outstanding-request overlap.

Parameters:
- TEX_BASE_ADDR, 32'h0000_0000, byte base address of the texture region; texture byte address = TEX_BASE_ADDR + {texture_addr_in, 2'b00}.
- RD_TIMEOUT, 1023, max cycles waited for avm_readdatavalid before the read is aborted.
- TIMEOUT_DATA, 32'hDEAD_BEEF, data returned on an aborted read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- texture_req_in  in  1  texture read request (held until handshake completes)
- texture_addr_in  in  24  texture word index
- texture_core_id_in  in  7  requesting core id (latched for debug only)
- texture_valid_out  out  1  read data valid
- texture_data_out  out  32  read data
- texture_read_done_in  in  1  requester has consumed data
- write_req_in  in  1  write request
- write_addr_in  in  32  byte address; bits [1:0] ignored
- write_data_in  in  32  write data
- write_core_id_in  in  7  requesting core id
- write_valid_out  out  1  write response valid
- write_done_out  out  1  write completed
- avm_address  out  32  Avalon byte address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  32  Avalon write data
- avm_byteenable  out  4  always 4'hF while read or write is asserted, else 4'h0
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; set on read timeout, cleared only by reset

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0; latched address/data 0; timeout counter 0; cache invalid. Reset mid-transaction abandons the Avalon access immediately (avm_read/avm_write drop asynchronously).
- States: IDLE, RD_CMD, RD_WAIT, RD_RESP, WR_CMD, WR_RESP.
- IDLE:
  - texture_req_in=1 → latch address/id, go RD_CMD.
  - Else write_req_in=1 → latch address/data/id, go WR_CMD.
  - Both high at once → texture wins; write stays pending.
- RD_CMD: avm_read=1 with the latched address, held stable. Leave for RD_WAIT on the first cycle avm_waitrequest=0.
- RD_WAIT:
  - Counter increments each cycle.
  - avm_readdatavalid=1 → latch avm_readdata, go RD_RESP.
  - Counter reaches RD_TIMEOUT → latch TIMEOUT_DATA, set err_timeout, go RD_RESP.
- RD_RESP:
  - texture_valid_out=1, texture_data_out=latched data, both held.
  - texture_read_done_in=1 → IDLE; valid drops the next cycle.
  - texture_req_in=0 (requester abandoned) → also IDLE.
- WR_CMD: avm_write=1, avm_address={write_addr[31:2],2'b00}, avm_writedata=latched data. Go WR_RESP on the first cycle avm_waitrequest=0.
- WR_RESP: write_valid_out=write_done_out=1 for exactly one cycle, then IDLE.
- Latency with zero-wait slave and 1-cycle read latency:
  - req in IDLE → avm_read next cycle → readdatavalid +1 → texture_valid_out +1 (3 cycles).
  - Write: req → avm_write +1 → done pulse +1 (2 cycles).
- Minimum one IDLE cycle between transactions, so the arbiter's return to IDLE is seen before a new request is sampled.
- avm_readdatavalid outside RD_WAIT is ignored. Address arithmetic is modulo 2^32.
- texture_data_out is held at its last value while valid is 0.

Optional Feature:
- Macro: CORE_MEM_BRIDGE_TEX_CACHE_EN.
- Defined: single-entry read cache holding (tag = texture byte address, data, valid bit).
  - Texture request in IDLE whose address equals a valid tag → go directly to RD_RESP with cached data next cycle; no Avalon access.
  - Every completed non-timeout read fills the entry.
  - A write whose word address equals the tag invalidates it in WR_CMD.
  - Reset invalidates it.
- Not defined: every texture request performs an Avalon read; no cache storage is synthesized.

Test Plan:
- Zero-wait read: texture_addr_in=24'h000010, TEX_BASE_ADDR=32'h1000_0000 → avm_address=32'h1000_0040; readdata=32'hCAFE_F00D → texture_valid_out=1, data=32'hCAFE_F00D held until read_done, then valid=0 next cycle.
- Stalled write: write_addr_in=32'h2000_0007, data=32'h1234_5678, waitrequest high 3 cycles → avm_write high 4 cycles at address 32'h2000_0004, byteenable=4'hF, then one-cycle write_valid_out=write_done_out=1.
- Timeout: readdatavalid never asserted, RD_TIMEOUT=8 → texture_data_out=32'hDEAD_BEEF after 8 RD_WAIT cycles; err_timeout=1 and stays 1 through later good reads.
- Simultaneous texture_req_in and write_req_in in IDLE → read fully completes first; write starts after one IDLE cycle.
- Reset asserted in RD_WAIT → avm_read, busy, texture_valid_out all 0 immediately; stale readdatavalid after reset release ignored.
- With CORE_MEM_BRIDGE_TEX_CACHE_EN: two reads of addr 24'h000020 → second gets valid one cycle after req with no avm_read. An intervening write to the matching byte address forces the third read to go to Avalon.
